sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider_if.sv | 24 ++
 rtl/sequential_divider.sv | 160 ++++++++++++++++
 tb/tb_sequential_divider.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// Handshake and result bundle for the sequential divider.
// The requester drives start/a/b; the divider returns the quotient, remainder and status.
interface sequential_divider_if #(
  parameter int l = 16
);
  logic         start;
  logic [l-1:0] a;
  logic [l-1:0] b;
  logic [l-1:0] r1;
  logic [l-1:0] r2;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, a, b,
    input  r1, r2, busy, done, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output r1, r2, busy, done, div_by_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider: one quotient bit per clock, l clocks per operation.
// A zero divisor finishes at once with an all-ones quotient and the dividend as remainder.
module sequential_divider #(
  parameter int l = 16
) (
  input  logic                clk,
  input  logic                rst,
  sequential_divider_if.slave bus
);

  localparam int cw = $clog2(l + 1);
  localparam logic [cw-1:0] cnt_load = cw'(l);
  localparam logic [cw-1:0] cnt_one  = cw'(1);
  localparam logic [l-1:0]  zero_w   = {l{1'b0}};
  localparam logic [l-1:0]  ones_w   = {l{1'b1}};

  typedef enum logic [1:0] {
    idle_st = 2'd0,
    run_st  = 2'd1,
    done_st = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [l-1:0]  b_r;
  logic [l-1:0]  q_r;
  logic [l-1:0]  rem_r;
  logic [cw-1:0] cnt_r;
  logic [l-1:0]  r1_r;
  logic [l-1:0]  r2_r;
  logic          dbz_r;

  logic          accept_s;
  logic          b_zero_s;
  logic [l:0]    rem_shift_s;
  logic [l:0]    diff_s;
  logic [l-1:0]  rem_next_s;
  logic [l-1:0]  q_next_s;
  logic          busy_s;
  logic          done_s;

  // Start acceptance and zero-divisor detection on the incoming operands
  always_comb begin
    accept_s = 1'b0;
    b_zero_s = (bus.b == zero_w);
    if ((state_r == idle_st) || (state_r == done_st)) begin
      accept_s = bus.start;
    end else begin
      accept_s = 1'b0;
    end
  end

  // One restoring step; the l+1-bit difference's top bit is the borrow, so no separate compare
  always_comb begin
    rem_shift_s = {rem_r, q_r[l-1]};
    diff_s      = rem_shift_s - {1'b0, b_r};
    rem_next_s  = rem_shift_s[l-1:0];
    q_next_s    = {q_r[l-2:0], 1'b0};
    if (diff_s[l] == 1'b0) begin
      rem_next_s = diff_s[l-1:0];
      q_next_s   = {q_r[l-2:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s[l-1:0];
      q_next_s   = {q_r[l-2:0], 1'b0};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= idle_st;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      idle_st, done_st: begin
        if (bus.start) begin
          state_next_s = b_zero_s ? done_st : run_st;
        end else begin
          state_next_s = idle_st;
        end
      end
      run_st: begin
        if (cnt_r == cnt_one) begin
          state_next_s = done_st;
        end else begin
          state_next_s = run_st;
        end
      end
      default: state_next_s = idle_st;
    endcase
  end

  // FSM output decode from the state register
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      idle_st: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      run_st: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      done_st: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_r   <= zero_w;
      q_r   <= zero_w;
      rem_r <= zero_w;
      cnt_r <= {cw{1'b0}};
      r1_r  <= zero_w;
      r2_r  <= zero_w;
      dbz_r <= 1'b0;
    end else if (accept_s) begin
      b_r   <= bus.b;
      q_r   <= bus.a;
      rem_r <= zero_w;
      cnt_r <= cnt_load;
      dbz_r <= b_zero_s;
      if (b_zero_s) begin
        r1_r <= ones_w;
        r2_r <= bus.a;
      end
    end else if (state_r == run_st) begin
      q_r   <= q_next_s;
      rem_r <= rem_next_s;
      cnt_r <= cnt_r - cnt_one;
      if (cnt_r == cnt_one) begin
        r1_r <= q_next_s;
        r2_r <= rem_next_s;
      end
    end
  end

  assign bus.r1          = r1_r;
  assign bus.r2          = r2_r;
  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider at l=16 and l=3: directed table, corner sequences
// and randomized operands against an arithmetic reference model.
module tb_sequential_divider;

  logic clk = 1'b0;
  logic rst16;
  logic rst3;

  sequential_divider_if #(.l(16)) if16();
  sequential_divider_if #(.l(3))  if3();

  sequential_divider #(.l(16)) dut16 (.clk(clk), .rst(rst16), .bus(if16));
  sequential_divider #(.l(3))  dut3  (.clk(clk), .rst(rst3),  .bus(if3));

  always #5 clk = ~clk;

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] prev_q [2];
  logic [15:0] prev_r [2];
  vec_t        vecs [12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b);
    if (w == 16) begin
      if16.start = st; if16.a = a; if16.b = b;
    end else begin
      if3.start = st; if3.a = a[2:0]; if3.b = b[2:0];
    end
  endtask

  task automatic sample(input int w, output logic [15:0] r1, output logic [15:0] r2,
                        output logic busy, output logic done, output logic dz);
    if (w == 16) begin
      r1 = if16.r1; r2 = if16.r2; busy = if16.busy; done = if16.done; dz = if16.div_by_zero;
    end else begin
      r1 = {13'd0, if3.r1}; r2 = {13'd0, if3.r2};
      busy = if3.busy; done = if3.done; dz = if3.div_by_zero;
    end
  endtask

  // Reference: plain integer division on the l-bit operands
  task automatic model(input int w, input logic [15:0] a_in, input logic [15:0] b_in,
                       output logic [15:0] q, output logic [15:0] r, output logic dz);
    logic [15:0] mask;
    logic [15:0] a;
    logic [15:0] b;
    mask = (w == 16) ? 16'hFFFF : 16'h0007;
    a = a_in & mask;
    b = b_in & mask;
    if (b == 16'd0) begin
      q = mask; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  // Called at a negedge: present the operands for one edge, return at the next negedge
  task automatic start_op(input int w, input logic [15:0] a, input logic [15:0] b);
    drive(w, 1'b1, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, a, b);
  endtask

  // Wait for done (bounded), checking latency, results and in-flight invariants
  task automatic finish_op(input int w, input logic [15:0] b, input int k0,
                           input logic [15:0] eq, input logic [15:0] er, input logic edz,
                           input string name);
    int          idx;
    int          k;
    int          busy_cnt;
    int          exp_k;
    logic        ok_hold;
    logic        ok_excl;
    logic [15:0] r1, r2, bm;
    logic        busy, done, dz;
    idx      = (w == 16) ? 0 : 1;
    bm       = (w == 16) ? b : (b & 16'h0007);
    exp_k    = (bm == 16'd0) ? 1 : w + 1;
    k        = k0;
    busy_cnt = 0;
    ok_hold  = 1'b1;
    ok_excl  = 1'b1;
    sample(w, r1, r2, busy, done, dz);
    while (!done && k < 60) begin
      if (busy) busy_cnt++;
      if (r1 !== prev_q[idx] || r2 !== prev_r[idx] || dz !== 1'b0) ok_hold = 1'b0;
      @(negedge clk);
      k++;
      sample(w, r1, r2, busy, done, dz);
    end
    if (busy && done) ok_excl = 1'b0;
    check({name, " latency"}, 16'(k), 16'(exp_k));
    check({name, " busy_cycles"}, 16'(busy_cnt), 16'(exp_k - k0));
    check({name, " hold"}, {15'd0, ok_hold}, 16'd1);
    check({name, " busy_done_excl"}, {15'd0, ok_excl}, 16'd1);
    check({name, " R1"}, r1, eq);
    check({name, " R2"}, r2, er);
    check({name, " DivByZero"}, {15'd0, dz}, {15'd0, edz});
    prev_q[idx] = eq;
    prev_r[idx] = er;
  endtask

  task automatic do_op(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz,
                       input string name);
    logic [15:0] r1, r2;
    logic        busy, done, dz;
    start_op(w, a, b);
    finish_op(w, b, 1, eq, er, edz, name);
    @(negedge clk);
    sample(w, r1, r2, busy, done, dz);
    check({name, " done_pulse"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    logic [15:0] r1, r2, a, b, eq, er;
    logic        busy, done, dz, edz, ok;

    rst16 = 1'b1;
    rst3  = 1'b1;
    drive(16, 1'b0, 16'd0, 16'd0);
    drive(3, 1'b0, 16'd0, 16'd0);
    prev_q[0] = 16'd0; prev_q[1] = 16'd0;
    prev_r[0] = 16'd0; prev_r[1] = 16'd0;

    // Reset values appear before any clock edge
    #1;
    for (int w = 3; w <= 16; w += 13) begin
      sample(w, r1, r2, busy, done, dz);
      check("reset R1", r1, 16'd0);
      check("reset R2", r2, 16'd0);
      check("reset flags", {13'd0, busy, done, dz}, 16'd0);
    end
    @(negedge clk);
    rst16 = 1'b0;
    rst3  = 1'b0;

    vecs[0]  = '{16, 16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
    vecs[1]  = '{16, 16'd5,     16'd0,     16'hFFFF,  16'd5,     1'b1};
    vecs[2]  = '{16, 16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0};
    vecs[3]  = '{3,  16'd7,     16'd3,     16'd2,     16'd1,     1'b0};
    vecs[4]  = '{3,  16'd3,     16'd7,     16'd0,     16'd3,     1'b0};
    vecs[5]  = '{3,  16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
    vecs[6]  = '{3,  16'd6,     16'd0,     16'd7,     16'd6,     1'b1};
    vecs[7]  = '{16, 16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0};
    vecs[8]  = '{16, 16'd40000, 16'd255,   16'd156,   16'd220,   1'b0};
    vecs[9]  = '{16, 16'd0,     16'd9,     16'd0,     16'd0,     1'b0};
    vecs[10] = '{16, 16'd1234,  16'd40000, 16'd0,     16'd1234,  1'b0};
    vecs[11] = '{3,  16'd7,     16'd1,     16'd7,     16'd0,     1'b0};

    foreach (vecs[i]) begin
      do_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
            $sformatf("vec%0d", i));
    end

    // Start during RUN is ignored, then Start held in the DONE cycle chains a new operation
    start_op(16, 16'd1000, 16'd10);
    repeat (2) @(negedge clk);
    drive(16, 1'b1, 16'd9, 16'd2);
    @(negedge clk);
    drive(16, 1'b0, 16'd9, 16'd2);
    finish_op(16, 16'd10, 4, 16'd100, 16'd0, 1'b0, "midrun");
    start_op(16, 16'd9, 16'd2);
    finish_op(16, 16'd2, 1, 16'd4, 16'd1, 1'b0, "backtoback");
    @(negedge clk);

    // Asynchronous reset in the middle of RUN
    start_op(16, 16'd500, 16'd3);
    repeat (4) @(negedge clk);
    #2 rst16 = 1'b1;
    #1 sample(16, r1, r2, busy, done, dz);
    check("async_rst R1", r1, 16'd0);
    check("async_rst R2", r2, 16'd0);
    check("async_rst flags", {13'd0, busy, done, dz}, 16'd0);
    @(negedge clk);
    rst16 = 1'b0;
    prev_q[0] = 16'd0;
    prev_r[0] = 16'd0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      sample(16, r1, r2, busy, done, dz);
      if (done || busy) ok = 1'b0;
    end
    check("abort no_done", {15'd0, ok}, 16'd1);
    do_op(16, 16'd500, 16'd3, 16'd166, 16'd2, 1'b0, "after_rst");

    // Randomized regression for both widths
    for (int n = 0; n < 1500; n++) begin
      for (int w = 3; w <= 16; w += 13) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = 16'hFFFF;
        model(w, a, b, eq, er, edz);
        do_op(w, a, b, eq, er, edz, $sformatf("rand%0d_l%0d", n, w));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
